maxpool_pair_feeder: RTL and testbench

- Upstream stage of the 2-input float max-pool comparator.
- Accepts a raster-order stream of IEEE-754 single-precision feature-map pixels and buffers one even row in a line buffer.
- On each odd row, presents vertically adjacent pixel pairs (row r-1, row r; same column) with a valid strobe that drives the comparator's enable.
- Pure data movement; no float arithmetic.

---
 rtl/maxpool_pair_feeder_if.sv | 38 +++
 rtl/maxpool_pair_feeder.sv | 106 ++++++++++
 tb/tb_maxpool_pair_feeder.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_pair_feeder_if.sv
// Stream-in / pair-out bundle of the max-pool pair feeder.
// MAXPOOL_PAIR_HPAIR_EN adds the pair_last window-close flag.
interface maxpool_pair_feeder_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
);
    logic              en;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pair_up;
    logic [DATA_W-1:0] pair_dn;
    logic              pair_valid;
    logic [CNT_W-1:0]  pair_col;
    logic [CNT_W-1:0]  pair_row;
    logic              frame_done;
`ifdef MAXPOOL_PAIR_HPAIR_EN
    logic              pair_last;

    modport master (
        output en, in_data, in_valid,
        input  in_ready, pair_up, pair_dn, pair_valid, pair_col, pair_row, frame_done, pair_last
    );
    modport slave (
        input  en, in_data, in_valid,
        output in_ready, pair_up, pair_dn, pair_valid, pair_col, pair_row, frame_done, pair_last
    );
`else
    modport master (
        output en, in_data, in_valid,
        input  in_ready, pair_up, pair_dn, pair_valid, pair_col, pair_row, frame_done
    );
    modport slave (
        input  en, in_data, in_valid,
        output in_ready, pair_up, pair_dn, pair_valid, pair_col, pair_row, frame_done
    );
`endif
endinterface

// File: rtl/maxpool_pair_feeder.sv
// Buffers each even row and emits vertical (row r-1, row r) pixel pairs on odd rows.
// Optional MAXPOOL_PAIR_HPAIR_EN adds pair_last for closing 2x2 windows.
module maxpool_pair_feeder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned IMG_H  = 8,
    parameter int unsigned CNT_W  = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    maxpool_pair_feeder_if.slave bus
);

    localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  row_q, row_d;
    logic              accept;
    logic              odd_row;
    logic              last_col;
    logic              last_row;
    logic [AW-1:0]     col_idx;
    logic [DATA_W-1:0] line_buf [IMG_W];

    logic [DATA_W-1:0] pair_up_q;
    logic [DATA_W-1:0] pair_dn_q;
    logic              pair_valid_q;
    logic [CNT_W-1:0]  pair_col_q;
    logic [CNT_W-1:0]  pair_row_q;
    logic              frame_done_q;

    assign bus.in_ready = bus.en;
    assign accept       = bus.en & bus.in_valid;
    assign odd_row      = row_q[0];
    assign last_col     = (col_q == CNT_W'(IMG_W - 1));
    assign last_row     = (row_q == CNT_W'(IMG_H - 1));
    assign col_idx      = col_q[AW-1:0];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + CNT_W'(1);
            end else begin
                col_d = col_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_up_q    <= '0;
            pair_dn_q    <= '0;
            pair_valid_q <= 1'b0;
            pair_col_q   <= '0;
            pair_row_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_valid_q <= accept & odd_row;
            frame_done_q <= accept & last_col & last_row;
            // Pair fields hold between emissions; only pair_valid drops.
            if (accept && odd_row) begin
                pair_up_q  <= line_buf[col_idx];
                pair_dn_q  <= bus.in_data;
                pair_col_q <= col_q;
                pair_row_q <= row_q >> 1;
            end
        end
    end

    // Line buffer is intentionally not reset; even rows always rewrite it before use.
    always_ff @(posedge clk) begin
        if (accept && !odd_row) begin
            line_buf[col_idx] <= bus.in_data;
        end
    end

    assign bus.pair_up    = pair_up_q;
    assign bus.pair_dn    = pair_dn_q;
    assign bus.pair_valid = pair_valid_q;
    assign bus.pair_col   = pair_col_q;
    assign bus.pair_row   = pair_row_q;
    assign bus.frame_done = frame_done_q;

`ifdef MAXPOOL_PAIR_HPAIR_EN
    logic pair_last_q;

    // Odd columns close a 2x2 window; an odd-width row's last column closes alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_last_q <= 1'b0;
        end else begin
            pair_last_q <= accept & odd_row & (col_q[0] | last_col);
        end
    end

    assign bus.pair_last = pair_last_q;
`endif

endmodule

// File: tb/tb_maxpool_pair_feeder.sv
// Bench for maxpool_pair_feeder: a 4x2 and an 8x8 instance checked against a pixel-index model.
module tb_maxpool_pair_feeder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    maxpool_pair_feeder_if #(.DATA_W(32), .CNT_W(8)) bus_a ();
    maxpool_pair_feeder_if #(.DATA_W(32), .CNT_W(8)) bus_b ();

    maxpool_pair_feeder #(.DATA_W(32), .IMG_W(4), .IMG_H(2), .CNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    maxpool_pair_feeder #(.DATA_W(32), .IMG_W(8), .IMG_H(8), .CNT_W(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    logic la, lb;
`ifdef MAXPOOL_PAIR_HPAIR_EN
    assign la = bus_a.pair_last;
    assign lb = bus_b.pair_last;
`else
    assign la = 1'b0;
    assign lb = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // Model: pixel n of a frame sits at row n/W, column n%W; odd rows pair with pixel n-W.
    int          mw [2] = '{4, 8};
    int          mh [2] = '{2, 8};
    int          mn [2] = '{0, 0};
    logic [31:0] img [2][64];
    logic        ev [2] = '{1'b0, 1'b0};
    logic        ed [2] = '{1'b0, 1'b0};
    logic        el [2] = '{1'b0, 1'b0};
    logic [31:0] eu [2] = '{32'h0, 32'h0};
    logic [31:0] edn [2] = '{32'h0, 32'h0};
    int          ec [2] = '{0, 0};
    int          er [2] = '{0, 0};
    int          pairs [2] = '{0, 0};
    int          dones [2] = '{0, 0};

    logic [31:0] fp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input logic acc, input logic [31:0] d);
        int r, c;
        ev[k] = 1'b0;
        ed[k] = 1'b0;
        el[k] = 1'b0;
        if (acc) begin
            r = mn[k] / mw[k];
            c = mn[k] % mw[k];
            img[k][mn[k]] = d;
            if (r % 2 == 1) begin
                ev[k]  = 1'b1;
                eu[k]  = img[k][mn[k] - mw[k]];
                edn[k] = d;
                ec[k]  = c;
                er[k]  = r / 2;
                el[k]  = (c % 2 == 1) || (c == mw[k] - 1);
            end
            mn[k]++;
            if (mn[k] == mw[k] * mh[k]) begin
                mn[k] = 0;
                ed[k] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mn[k] = 0; ev[k] = 1'b0; ed[k] = 1'b0; el[k] = 1'b0;
                eu[k] = '0; edn[k] = '0; ec[k] = 0; er[k] = 0;
            end
        end else begin
            model_step(0, bus_a.en & bus_a.in_valid, bus_a.in_data);
            model_step(1, bus_b.en & bus_b.in_valid, bus_b.in_data);
        end
    end

    task automatic cmp(input int k, input logic v, input logic fd, input logic [31:0] up,
                       input logic [31:0] dn, input logic [7:0] col, input logic [7:0] row,
                       input logic last, input logic rdy, input logic en);
        string t;
        t = (k == 0) ? "a" : "b";
        if (v === 1'b1) pairs[k]++;
        if (fd === 1'b1) dones[k]++;
        chk({t, "_pair_valid"}, 32'(v), 32'(ev[k]));
        chk({t, "_frame_done"}, 32'(fd), 32'(ed[k]));
        chk({t, "_pair_up"}, up, eu[k]);
        chk({t, "_pair_dn"}, dn, edn[k]);
        chk({t, "_pair_col"}, 32'(col), 32'(ec[k]));
        chk({t, "_pair_row"}, 32'(row), 32'(er[k]));
        chk({t, "_in_ready"}, 32'(rdy), 32'(en));
`ifdef MAXPOOL_PAIR_HPAIR_EN
        chk({t, "_pair_last"}, 32'(last), 32'(el[k]));
`else
        if (last !== 1'b0) chk({t, "_pair_last_tie"}, 32'(last), 32'h0);
`endif
    endtask

    always @(negedge clk) begin
        cmp(0, bus_a.pair_valid, bus_a.frame_done, bus_a.pair_up, bus_a.pair_dn,
            bus_a.pair_col, bus_a.pair_row, la, bus_a.in_ready, bus_a.en);
        cmp(1, bus_b.pair_valid, bus_b.frame_done, bus_b.pair_up, bus_b.pair_dn,
            bus_b.pair_col, bus_b.pair_row, lb, bus_b.in_ready, bus_b.en);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] d);
        tick();
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d;
    endtask

    task automatic idle_a();
        tick();
        bus_a.in_valid = 1'b0;
    endtask

    initial begin
        int i, cyc, pause_cnt, p;
        logic was_paused;
        bus_a.en = 1'b1; bus_a.in_valid = 1'b0; bus_a.in_data = '0;
        bus_b.en = 1'b1; bus_b.in_valid = 1'b0; bus_b.in_data = '0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        chk("reset_pair_valid", 32'(bus_a.pair_valid), 32'h0);
        chk("reset_pair_up", bus_b.pair_up, 32'h0);
        #2 rst_n = 1'b1;

        // 4x2 frame of 1.0..8.0, back to back.
        for (int n = 0; n <= 8; n++) begin
            if (n < 8) push_a(fp[n]); else idle_a();
            if (n >= 1) begin
                p = n - 1;
                chk("t1_valid", 32'(bus_a.pair_valid), (p >= 4) ? 32'h1 : 32'h0);
                if (p >= 4) begin
                    chk("t1_up", bus_a.pair_up, fp[p-4]);
                    chk("t1_dn", bus_a.pair_dn, fp[p]);
                    chk("t1_col", 32'(bus_a.pair_col), 32'(p - 4));
                    chk("t1_row", 32'(bus_a.pair_row), 32'h0);
`ifdef MAXPOOL_PAIR_HPAIR_EN
                    chk("t1_last", 32'(bus_a.pair_last), 32'(p % 2));
`endif
                end
                if (p == 4) begin
                    chk("t1_up_col0", bus_a.pair_up, 32'h3F800000);
                    chk("t1_dn_col0", bus_a.pair_dn, 32'h40A00000);
                end
                chk("t1_frame_done", 32'(bus_a.frame_done), (n == 8) ? 32'h1 : 32'h0);
            end
        end
        idle_a();
        chk("t1_frame_done_clear", 32'(bus_a.frame_done), 32'h0);

        // 8x8 frame, in_valid toggling, en low 5 cycles mid-row 3.
        pairs[1] = 0;
        dones[1] = 0;
        i = 0; cyc = 0; pause_cnt = 0; was_paused = 1'b0;
        while (i < 64 && cyc < 1000) begin
            tick();
            cyc++;
            if (was_paused) chk("t2_pause_valid", 32'(bus_b.pair_valid), 32'h0);
            if (i == 27 && pause_cnt < 5) begin
                bus_b.en       = 1'b0;
                bus_b.in_valid = 1'b1;
                bus_b.in_data  = 32'hDEADBEEF;
                pause_cnt++;
                was_paused = 1'b1;
                #1 chk("t2_pause_ready", 32'(bus_b.in_ready), 32'h0);
            end else begin
                bus_b.en       = 1'b1;
                bus_b.in_valid = cyc[0];
                was_paused     = 1'b0;
                if (cyc[0]) begin
                    bus_b.in_data = 32'h41000000 | 32'(i);
                    i++;
                end else begin
                    bus_b.in_data = 32'hFFFFFFFF;
                end
            end
        end
        tick();
        bus_b.in_valid = 1'b0;
        repeat (3) tick();
        chk("t2_pair_count", 32'(pairs[1]), 32'd32);
        chk("t2_frame_done_count", 32'(dones[1]), 32'd1);
        chk("t2_last_row", 32'(bus_b.pair_row), 32'd3);

        // Async reset mid-row 1 at column 2.
        for (int n = 0; n < 6; n++) push_a(32'h42000000 | 32'(n));
        idle_a();
        #2 rst_n = 1'b0;
        #1;
        chk("t3_rst_valid", 32'(bus_a.pair_valid), 32'h0);
        chk("t3_rst_up", bus_a.pair_up, 32'h0);
        chk("t3_rst_dn", bus_a.pair_dn, 32'h0);
        chk("t3_rst_col", 32'(bus_a.pair_col), 32'h0);
        tick();
        #2 rst_n = 1'b1;
        for (int n = 0; n < 8; n++) push_a(32'h43000000 | 32'(n));
        idle_a();
        chk("t3_new_up", bus_a.pair_up, 32'h43000003);
        chk("t3_new_dn", bus_a.pair_dn, 32'h43000007);
        chk("t3_new_done", 32'(bus_a.frame_done), 32'h1);

        // Bit-exact passthrough of -1.0 over +inf.
        push_a(32'hBF800000);
        push_a(32'h00000001);
        push_a(32'h00000002);
        push_a(32'h00000003);
        push_a(32'h7F800000);
        push_a(32'h80000000);
        chk("t4_up", bus_a.pair_up, 32'hBF800000);
        chk("t4_dn", bus_a.pair_dn, 32'h7F800000);
        chk("t4_col", 32'(bus_a.pair_col), 32'h0);
        push_a(32'h00000006);
        push_a(32'h00000007);
        idle_a();
        repeat (3) idle_a();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
